// File: rtl/ls_pwm_gen_multi_if.sv
// Configuration bus for the multi-channel low-speed PWM generator.
// The host drives the staging-register writes through the master side.
interface ls_pwm_gen_multi_if #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic               cfg_wr;
    logic [CH_W-1:0]    cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_duty;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_pol;

    modport master (
        output cfg_wr, cfg_ch, cfg_period,
        output cfg_duty, cfg_burst, cfg_pol
    );

    modport slave (
        input cfg_wr, cfg_ch, cfg_period,
        input cfg_duty, cfg_burst, cfg_pol
    );
endinterface

// File: rtl/ls_pwm_gen_multi.sv
// Multi-channel low-speed PWM generator with staged/active config,
// programmable period, duty, polarity and burst length per channel.
module ls_pwm_gen_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic                clk_50M_o,
    input  logic                rst_n,
    ls_pwm_gen_multi_if.slave   cfg,
    input  logic [NUM_CH-1:0]   ch_start,
    input  logic [NUM_CH-1:0]   ch_stop,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic [NUM_CH-1:0]   ch_busy,
    output logic [NUM_CH-1:0]   ch_done
);

    typedef struct packed {
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   duty;
        logic [BURST_W-1:0] burst;
        logic               pol;
    } cfg_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    cfg_t w_wr_cfg;

    assign w_wr_cfg = {cfg.cfg_period, cfg.cfg_duty,
                       cfg.cfg_burst, cfg.cfg_pol};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cfg_t               r_stg;
        cfg_t               r_act;
        state_t             r_st;
        logic [CNT_W-1:0]   r_cnt;
        logic [BURST_W-1:0] r_pcnt;
        logic               r_pwm;
        logic               r_busy;
        logic               r_done;

        logic               w_sel;
        logic               w_wrap;
        logic               w_last;
        logic [CNT_W-1:0]   w_cnt_inc;
        logic [BURST_W-1:0] w_pcnt_inc;

        // Out-of-range channel numbers never match, so they are dropped.
        assign w_sel      = cfg.cfg_wr && (int'(cfg.cfg_ch) == i);
        assign w_wrap     = (r_cnt == r_act.period);
        assign w_cnt_inc  = r_cnt + CNT_W'(1);
        assign w_pcnt_inc = r_pcnt + BURST_W'(1);
        assign w_last     = (r_act.burst != '0) &&
                            (w_pcnt_inc == r_act.burst);

        always_ff @(posedge clk_50M_o or negedge rst_n) begin
            if (!rst_n) begin
                r_stg  <= '0;
                r_act  <= '0;
                r_st   <= S_IDLE;
                r_cnt  <= '0;
                r_pcnt <= '0;
                r_pwm  <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b0;
            end else begin
                r_done <= 1'b0;
                if (w_sel) begin
                    r_stg <= w_wr_cfg;
                end
                unique case (r_st)
                    S_IDLE: begin
                        if (ch_start[i] && !ch_stop[i]) begin
                            r_st   <= S_RUN;
                            r_act  <= r_stg;
                            r_cnt  <= '0;
                            r_pcnt <= '0;
                            r_busy <= 1'b1;
                            r_pwm  <= (r_stg.duty != '0) ^ r_stg.pol;
                        end else begin
                            r_pwm <= r_stg.pol;
                        end
                    end
                    S_RUN: begin
                        if (ch_stop[i]) begin
                            r_st   <= S_IDLE;
                            r_busy <= 1'b0;
                            r_pwm  <= r_stg.pol;
                        end else if (w_wrap && w_last) begin
                            r_st   <= S_IDLE;
                            r_cnt  <= '0;
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                            r_pwm  <= r_stg.pol;
                        end else if (w_wrap) begin
                            // Reload uses the staging value from before
                            // any write landing in this same cycle.
                            r_act <= r_stg;
                            r_cnt <= '0;
                            if (r_pcnt != '1) begin
                                r_pcnt <= w_pcnt_inc;
                            end
                            r_pwm <= (r_stg.duty != '0) ^ r_stg.pol;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            r_pwm <= (w_cnt_inc < r_act.duty) ^
                                     r_act.pol;
                        end
                    end
                    default: r_st <= S_IDLE;
                endcase
            end
        end

        assign pwm_out[i] = r_pwm;
        assign ch_busy[i] = r_busy;
        assign ch_done[i] = r_done;
    end

endmodule

// File: tb/tb_ls_pwm_gen_multi.sv
// Directed bench for ls_pwm_gen_multi: reset, waveforms, bursts,
// live updates, stop/start collisions and duty boundaries.
module tb_ls_pwm_gen_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic              clk_50M_o;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_start;
    logic [NUM_CH-1:0] ch_stop;
    logic [NUM_CH-1:0] pwm_out;
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] ch_done;

    int n_tests;
    int n_fail;

    ls_pwm_gen_multi_if #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)
    ) cfg_if ();

    ls_pwm_gen_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)
    ) dut (
        .clk_50M_o(clk_50M_o),
        .rst_n    (rst_n),
        .cfg      (cfg_if),
        .ch_start (ch_start),
        .ch_stop  (ch_stop),
        .pwm_out  (pwm_out),
        .ch_busy  (ch_busy),
        .ch_done  (ch_done)
    );

    initial clk_50M_o = 1'b0;
    always #10 clk_50M_o = ~clk_50M_o;

    task automatic tick();
        @(posedge clk_50M_o);
        #1;
    endtask

    task automatic set_cfg(input int ch, input int per,
                           input int duty, input int burst,
                           input bit pol);
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_period = 16'(per);
        cfg_if.cfg_duty   = 16'(duty);
        cfg_if.cfg_burst  = 8'(burst);
        cfg_if.cfg_pol    = pol;
    endtask

    task automatic cfg_write(input int ch, input int per,
                             input int duty, input int burst,
                             input bit pol);
        set_cfg(ch, per, duty, burst, pol);
        cfg_if.cfg_wr = 1'b1;
        tick();
        cfg_if.cfg_wr = 1'b0;
    endtask

    task automatic pulse_start(input int ch);
        ch_start[ch] = 1'b1;
        tick();
        ch_start[ch] = 1'b0;
    endtask

    task automatic pulse_stop(input int ch);
        ch_stop[ch] = 1'b1;
        tick();
        ch_stop[ch] = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (pwm_out !== 4'h0 || ch_busy !== 4'h0 || ch_done !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: pwm=%b busy=%b done=%b want 0",
                     pwm_out, ch_busy, ch_done);
        end
        cfg_write(0, 9, 5, 0, 1'b0);
        pulse_start(0);
        repeat (2) tick();
        n_tests++;
        if (ch_busy[0] !== 1'b1 || pwm_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prerun: busy=%b pwm=%b want 1 1",
                     ch_busy[0], pwm_out[0]);
        end
        #3 rst_n = 1'b0;
        #2;
        n_tests++;
        if (pwm_out !== 4'h0 || ch_busy !== 4'h0 || ch_done !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_async: pwm=%b busy=%b done=%b want 0",
                     pwm_out, ch_busy, ch_done);
        end
        tick();
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            n_tests++;
            if (ch_busy !== 4'h0 || pwm_out !== 4'h0 ||
                ch_done !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_after: busy=%b pwm=%b done=%b want 0",
                         ch_busy, pwm_out, ch_done);
            end
        end
    endtask

    task automatic test_continuous();
        logic exp;
        cfg_write(0, 499, 250, 0, 1'b0);
        pulse_start(0);
        for (int k = 0; k < 1500; k++) begin
            exp = ((k % 500) < 250);
            n_tests++;
            if (pwm_out[0] !== exp || ch_busy[0] !== 1'b1 ||
                ch_done[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL cont_k%0d: pwm=%b busy=%b done=%b want %b 1 0",
                         k, pwm_out[0], ch_busy[0], ch_done[0], exp);
            end
            tick();
        end
        pulse_stop(0);
        n_tests++;
        if (ch_busy[0] !== 1'b0 || pwm_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_stop: busy=%b pwm=%b want 0 0",
                     ch_busy[0], pwm_out[0]);
        end
    endtask

    task automatic test_burst();
        logic exp;
        cfg_write(1, 9, 3, 3, 1'b0);
        pulse_start(1);
        for (int k = 0; k < 30; k++) begin
            exp = ((k % 10) < 3);
            n_tests++;
            if (pwm_out[1] !== exp || ch_busy[1] !== 1'b1 ||
                ch_done[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL burst_k%0d: pwm=%b busy=%b done=%b want %b 1 0",
                         k, pwm_out[1], ch_busy[1], ch_done[1], exp);
            end
            n_tests++;
            if (ch_busy[3:2] !== 2'b00 || ch_busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL burst_indep_k%0d: busy=%b want 0010",
                         k, ch_busy);
            end
            tick();
        end
        n_tests++;
        if (ch_done[1] !== 1'b1 || ch_busy[1] !== 1'b0 ||
            pwm_out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: done=%b busy=%b pwm=%b want 1 0 0",
                     ch_done[1], ch_busy[1], pwm_out[1]);
        end
        tick();
        n_tests++;
        if (ch_done[1] !== 1'b0 || ch_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_post: done=%b busy=%b want 0 0",
                     ch_done[1], ch_busy[1]);
        end
    endtask

    task automatic test_update();
        logic exp;
        int   d;
        cfg_write(0, 9, 3, 0, 1'b0);
        pulse_start(0);
        set_cfg(0, 9, 3, 0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            d   = (k < 10) ? 3 : (k < 30) ? 7 : 2;
            exp = ((k % 10) < d);
            n_tests++;
            if (pwm_out[0] !== exp) begin
                n_fail++;
                $display("FAIL update_k%0d: pwm=%b want %b",
                         k, pwm_out[0], exp);
            end
            cfg_if.cfg_wr = 1'b0;
            if (k == 4) begin
                set_cfg(0, 9, 7, 0, 1'b0);
                cfg_if.cfg_wr = 1'b1;
            end
            if (k == 19) begin
                set_cfg(0, 9, 2, 0, 1'b0);
                cfg_if.cfg_wr = 1'b1;
            end
            tick();
        end
        cfg_if.cfg_wr = 1'b0;
        pulse_stop(0);
    endtask

    task automatic test_stop();
        logic exp;
        cfg_write(2, 9, 5, 0, 1'b0);
        pulse_start(2);
        for (int k = 0; k < 5; k++) tick();
        pulse_stop(2);
        n_tests++;
        if (ch_busy[2] !== 1'b0 || pwm_out[2] !== 1'b0 ||
            ch_done[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_next: busy=%b pwm=%b done=%b want 0 0 0",
                     ch_busy[2], pwm_out[2], ch_done[2]);
        end
        repeat (12) begin
            tick();
            n_tests++;
            if (ch_done[2] !== 1'b0 || ch_busy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_nodone: done=%b busy=%b want 0 0",
                         ch_done[2], ch_busy[2]);
            end
        end
        ch_start[2] = 1'b1;
        ch_stop[2]  = 1'b1;
        tick();
        ch_start[2] = 1'b0;
        ch_stop[2]  = 1'b0;
        n_tests++;
        if (ch_busy[2] !== 1'b0 || pwm_out[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same: busy=%b pwm=%b want 0 0",
                     ch_busy[2], pwm_out[2]);
        end
        tick();
        n_tests++;
        if (ch_busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_hold: busy=%b want 0", ch_busy[2]);
        end
        pulse_start(2);
        for (int k = 0; k < 20; k++) begin
            exp = ((k % 10) < 5);
            n_tests++;
            if (pwm_out[2] !== exp || ch_busy[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL start_busy_k%0d: pwm=%b busy=%b want %b 1",
                         k, pwm_out[2], ch_busy[2], exp);
            end
            ch_start[2] = (k == 3);
            tick();
        end
        ch_start[2] = 1'b0;
        pulse_stop(2);
    endtask

    task automatic test_boundary();
        cfg_write(3, 9, 0, 0, 1'b1);
        pulse_start(3);
        for (int k = 0; k < 20; k++) begin
            n_tests++;
            if (pwm_out[3] !== 1'b1 || ch_busy[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL duty0_pol1_k%0d: pwm=%b busy=%b want 1 1",
                         k, pwm_out[3], ch_busy[3]);
            end
            tick();
        end
        pulse_stop(3);
        cfg_write(3, 9, 20, 0, 1'b0);
        pulse_start(3);
        for (int k = 0; k < 20; k++) begin
            n_tests++;
            if (pwm_out[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL duty_gt_per_k%0d: pwm=%b want 1",
                         k, pwm_out[3]);
            end
            tick();
        end
        pulse_stop(3);
        cfg_write(3, 0, 1, 0, 1'b0);
        pulse_start(3);
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (pwm_out[3] !== 1'b1 || ch_busy[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL period0_k%0d: pwm=%b busy=%b want 1 1",
                         k, pwm_out[3], ch_busy[3]);
            end
            tick();
        end
        pulse_stop(3);
        n_tests++;
        if (pwm_out[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_pol0: pwm=%b want 0", pwm_out[3]);
        end
        cfg_write(3, 9, 4, 0, 1'b1);
        tick();
        n_tests++;
        if (pwm_out[3] !== 1'b1 || ch_busy[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_pol1: pwm=%b busy=%b want 1 0",
                     pwm_out[3], ch_busy[3]);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        ch_start      = '0;
        ch_stop       = '0;
        cfg_if.cfg_wr = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_continuous();
        test_burst();
        test_update();
        test_stop();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
